decoder_n_seq: RTL

Parametrised, registered N-to-2^N one-hot decoder. It is the sequential successor to the team's fixed 3-to-8 dataflow decoder. It adds a valid/ready input handshake, a registered output with a valid flag, and an optional auto-scan mode that walks the one-hot output through every line with a programmable dwell time. It sits between control logic and line-select fabric, for example chip selects, LED or row scanning, and mux enables.

---
 rtl/decoder_n_seq_pkg.sv | 13 +
 rtl/decoder_n_seq_dwell_timer.sv | 29 ++
 rtl/decoder_n_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/decoder_n_seq_pkg.sv
// Shared types and constants for the registered one-hot decoder.
package decoder_n_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_n_seq_pkg

// File: rtl/decoder_n_seq_dwell_timer.sv
// Dwell counter for auto-scan: counts while run is high and ticks when the
// count reaches (or has been overtaken by) the programmed dwell.
module decoder_n_seq_dwell_timer #(
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic                   tick
);

  logic [DWELL_WIDTH-1:0] count_r;

  // >= rather than == so a dwell lowered below the count still advances next edge
  assign tick = run && (count_r >= dwell);

  // Count register: cleared while idle and on every tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {DWELL_WIDTH{1'b0}};
    end else if (!run || tick) begin
      count_r <= {DWELL_WIDTH{1'b0}};
    end else begin
      count_r <= count_r + DWELL_WIDTH'(1);
    end
  end

endmodule : decoder_n_seq_dwell_timer

// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and optional
// auto-scan mode, enabled by defining DECODER_N_SEQ_SCAN_EN.
module decoder_n_seq
  import decoder_n_seq_pkg::*;
#(
  parameter int IN_WIDTH    = 3,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_lines,
  input  logic [DWELL_WIDTH-1:0]     dwell,
  output logic [(1<<IN_WIDTH)-1:0]   out_lines,
  output logic                       out_valid,
  output logic                       scan_wrap
);

  localparam int OUT_WIDTH = 1 << IN_WIDTH;

  function automatic logic [OUT_WIDTH-1:0] onehot_f(input logic [IN_WIDTH-1:0] idx);
    onehot_f = OUT_WIDTH'(1) << idx;
  endfunction

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic                   mode_eff_s;
  logic                   tick_s;
  logic                   xfer_s;
  logic [IN_WIDTH-1:0]    scan_idx_r;
  logic [IN_WIDTH-1:0]    scan_idx_nxt_s;
  logic [OUT_WIDTH-1:0]   out_lines_r;
  logic [OUT_WIDTH-1:0]   out_lines_nxt_s;
  logic                   out_valid_r;
  logic                   out_valid_nxt_s;
  logic                   in_ready_r;
  logic                   scan_wrap_r;
  logic                   scan_wrap_nxt_s;

`ifdef DECODER_N_SEQ_SCAN_EN
  assign mode_eff_s = mode;

  decoder_n_seq_dwell_timer #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_r == SCAN),
    .dwell (dwell),
    .tick  (tick_s)
  );
`else
  logic unused_s;
  assign unused_s   = ^{mode, dwell};
  assign mode_eff_s = MODE_DIRECT;
  assign tick_s     = 1'b0;
`endif

  assign xfer_s = (state_r == DECODE) && in_ready_r && in_valid;

  // Next state: any mode change while enabled goes through IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = (mode_eff_s == MODE_SCAN) ? SCAN : DECODE;
        DECODE:  state_nxt_s = (mode_eff_s == MODE_SCAN) ? IDLE : DECODE;
        SCAN:    state_nxt_s = (mode_eff_s == MODE_SCAN) ? SCAN : IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output and scan-index next values, keyed on the state being entered
  always_comb begin
    scan_idx_nxt_s  = {IN_WIDTH{1'b0}};
    out_lines_nxt_s = out_lines_r;
    out_valid_nxt_s = out_valid_r;
    scan_wrap_nxt_s = 1'b0;
    case (state_nxt_s)
      DECODE: begin
        if (xfer_s) begin
          out_lines_nxt_s = onehot_f(in_lines);
          out_valid_nxt_s = 1'b1;
        end else begin
          out_lines_nxt_s = out_lines_r;
          out_valid_nxt_s = out_valid_r;
        end
      end
      SCAN: begin
        if (state_r != SCAN) begin
          scan_idx_nxt_s = {IN_WIDTH{1'b0}};
        end else if (tick_s) begin
          scan_idx_nxt_s  = scan_idx_r + IN_WIDTH'(1);
          scan_wrap_nxt_s = (scan_idx_r == {IN_WIDTH{1'b1}});
        end else begin
          scan_idx_nxt_s = scan_idx_r;
        end
        out_lines_nxt_s = onehot_f(scan_idx_nxt_s);
        out_valid_nxt_s = 1'b1;
      end
      default: begin
        out_lines_nxt_s = {OUT_WIDTH{1'b0}};
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      scan_idx_r  <= {IN_WIDTH{1'b0}};
      out_lines_r <= {OUT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      scan_wrap_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      scan_idx_r  <= scan_idx_nxt_s;
      out_lines_r <= out_lines_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      in_ready_r  <= (state_nxt_s == DECODE);
      scan_wrap_r <= scan_wrap_nxt_s;
    end
  end

  assign out_lines = out_lines_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign scan_wrap = scan_wrap_r;

endmodule : decoder_n_seq
